tpu_layer_sequencer: RTL and testbench
======================================

// Module: tpu_layer_sequencer
// PURPOSE
//  Parametrised top-level sequencer for an N-layer fully-connected inference chain.
//  Runs layer engines one at a time and time-multiplexes the shared ROM port and MAC
//  operands onto the active engine. Accumulates a sticky overflow flag, captures the
//  argmax class index, and aborts via a watchdog when an engine hangs.
//  Sits between the image source and the layer engines / shared block_mem / TPU_MultAdd.
// PARAMETERS
//  NUM_LAYERS   2     number of layer engines (>=1); sequenced from index 0 upward
//  BIT          16    operand element width
//  LANES        128   elements per MAC operand vector
//  ADDR_W       11    ROM address width
//  IDX_W        4     class-index width
//  TIMEOUT_CYC  4096  maximum RUN cycles per layer; 0 disables the watchdog
// PORTS
//  clk          in   1                   clock, rising edge
//  iRst_n       in   1                   reset, asynchronous, active-low
//  ena          in   1                   global enable; low freezes the FSM and watchdog
//  start        in   1                   single-cycle pulse that begins an inference
//  layer_done   in   NUM_LAYERS          per-engine completion level
//  layer_ovf    in   NUM_LAYERS          per-engine overflow, valid while layer_done is high
//  layer_addr   in   NUM_LAYERS*ADDR_W   per-engine ROM address, flattened, engine 0 at LSBs
//  layer_opr1   in   NUM_LAYERS*LANES*BIT  per-engine MAC operand 1, flattened
//  layer_opr2   in   NUM_LAYERS*LANES*BIT  per-engine MAC operand 2, flattened
//  class_index  in   IDX_W               argmax of the final engine's output
//  layer_ena    out  NUM_LAYERS          one-hot enable of the active engine
//  layer_rstn   out  NUM_LAYERS          per-engine active-low synchronous reset strobe
//  rom_addr     out  ADDR_W              muxed ROM address
//  mac_opr1     out  LANES*BIT           muxed MAC operand 1
//  mac_opr2     out  LANES*BIT           muxed MAC operand 2
//  busy         out  1                   high from the start sample until done or timeout
//  done         out  1                   level; result valid
//  overflow     out  1                   sticky OR of all layer_ovf values in this run
//  timeout      out  1                   watchdog abort flag
//  num_out      out  IDX_W               captured class index
// BEHAVIOUR
//  - Reset (async assert, sync release) forces state=IDLE, idx=0, wdog=0, busy=0, done=0,
//    overflow=0, timeout=0, num_out=0, layer_ena=0, and layer_rstn=all 1s.
//  - States:
//    IDLE
//    RST   layer_ena[idx]=1, layer_rstn[idx]=0, one cycle
//    RUN   layer_ena[idx]=1, layer_rstn[idx]=1
//    DONE
//    ERR
//  - layer_ena and layer_rstn are Moore decodes of the registered state and idx
//    (glitch-free). All non-active bits are ena=0 and rstn=1.
//  - IDLE/DONE/ERR + start: clear done, overflow and timeout; set idx=0, busy=1;
//    go to RST. start is ignored in RST and RUN.
//  - RST -> RUN unconditionally; wdog is cleared.
//  - RUN with layer_done[idx] high:
//    overflow |= layer_ovf[idx].
//    If idx==NUM_LAYERS-1: num_out<=class_index, done<=1, busy<=0, go to DONE.
//    Otherwise: idx<=idx+1 and go to RST.
//  - RUN without layer_done[idx]: wdog++. If wdog reaches TIMEOUT_CYC-1 (and TIMEOUT_CYC!=0):
//    go to ERR with timeout=1, done=1, busy=0; num_out and overflow are unchanged.
//  - ena low: state, idx, wdog and all flags hold; outputs keep their decoded values.
//  - Latency: done rises sum over k of (1 + D_k) cycles after the start sample,
//    where D_k counts RUN cycles up to and including the one in which layer_done is sampled high.
//  - Mux outputs are combinational from idx, driven only in RST and RUN; otherwise all zeros.
//    No tri-states.
//  - NUM_LAYERS=1 is legal; idx width is max(1, $clog2(NUM_LAYERS)).
// STRUCTURE
//  - tpu_pkg: state enum (IDLE, RST, RUN, DONE, ERR) and default BIT, LANES and ADDR_W localparams.
//  - Sub-module tpu_operand_mux #(WIDTH, N): indexed slice select with a zero default.
//    Instantiated for rom_addr, mac_opr1 and mac_opr2.
//  - ROM data and MAC result are broadcast externally; engines gate on their own layer_ena.
// TESTING
//  1. N=2; stubs assert done after D=5 and D=3; class_index=7.
//     -> done=1, num_out=7, overflow=0, exactly 10 cycles after the start sample.
//  2. Engine 0 asserts layer_ovf=1 with its done.
//     -> overflow=1 at the end of the run; it stays 1 until the next start, which clears it.
//  3. TIMEOUT_CYC=16; engine 1 never asserts done.
//     -> ERR after 16 RUN cycles with timeout=1, done=1, busy=0, layer_ena=0, num_out=0.
//  4. Assert iRst_n low mid-RUN with no clock edge.
//     -> all outputs take their reset values immediately; a fresh start then completes normally.
//  5. ena low for 4 cycles during RUN, plus a start pulse while busy.
//     -> completion is delayed by exactly 4 cycles, the watchdog does not advance,
//        and the start pulse has no effect.
//  6. Drive distinct per-engine addr/opr patterns.
//     -> rom_addr and mac_opr1/2 equal slice idx during RST/RUN; all zeros in IDLE, DONE and ERR.

Source files
------------

// File: rtl/tpu_pkg.sv
// Shared types and default widths for the TPU layer sequencer slice.
package tpu_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RST  = 3'd1,
    RUN  = 3'd2,
    DONE = 3'd3,
    ERR  = 3'd4
  } state_e;

  localparam int unsigned DEF_BIT    = 16;
  localparam int unsigned DEF_LANES  = 128;
  localparam int unsigned DEF_ADDR_W = 11;

endpackage

// File: rtl/tpu_operand_mux.sv
// Selects one WIDTH-bit slice of a flattened N-entry bus; zero when disabled.
module tpu_operand_mux #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned N     = 2,
  parameter int unsigned SEL_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N*WIDTH-1:0] in_flat,
  input  logic [SEL_W-1:0]   sel,
  input  logic               en,
  output logic [WIDTH-1:0]   out_c
);

  always_comb begin
    out_c = '0;
    for (int i = 0; i < N; i++) begin
      if (en && (sel == SEL_W'(i))) begin
        out_c = in_flat[i*WIDTH +: WIDTH];
      end
    end
  end

endmodule

// File: rtl/tpu_layer_sequencer.sv
// Sequences N layer engines one at a time, muxes the shared ROM/MAC port onto the
// active engine, and tracks overflow, the final class index and a per-layer watchdog.
module tpu_layer_sequencer
  import tpu_pkg::*;
#(
  parameter int unsigned NUM_LAYERS  = 2,
  parameter int unsigned BIT         = DEF_BIT,
  parameter int unsigned LANES       = DEF_LANES,
  parameter int unsigned ADDR_W      = DEF_ADDR_W,
  parameter int unsigned IDX_W       = 4,
  parameter int unsigned TIMEOUT_CYC = 4096
) (
  input  logic                          clk,
  input  logic                          iRst_n,
  input  logic                          ena,
  input  logic                          start,
  input  logic [NUM_LAYERS-1:0]         layer_done,
  input  logic [NUM_LAYERS-1:0]         layer_ovf,
  input  logic [NUM_LAYERS*ADDR_W-1:0]  layer_addr,
  input  logic [NUM_LAYERS*LANES*BIT-1:0] layer_opr1,
  input  logic [NUM_LAYERS*LANES*BIT-1:0] layer_opr2,
  input  logic [IDX_W-1:0]              class_index,
  output logic [NUM_LAYERS-1:0]         layer_ena,
  output logic [NUM_LAYERS-1:0]         layer_rstn,
  output logic [ADDR_W-1:0]             rom_addr,
  output logic [LANES*BIT-1:0]          mac_opr1,
  output logic [LANES*BIT-1:0]          mac_opr2,
  output logic                          busy,
  output logic                          done,
  output logic                          overflow,
  output logic                          timeout,
  output logic [IDX_W-1:0]              num_out
);

  localparam int unsigned IDX_BITS = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;
  localparam int unsigned WDOG_W   = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int unsigned OPR_W    = LANES * BIT;

  state_e                state_q, state_d;
  logic [IDX_BITS-1:0]   idx_q, idx_d;
  logic [WDOG_W-1:0]     wdog_q, wdog_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  ovf_q, ovf_d;
  logic                  timeout_q, timeout_d;
  logic [IDX_W-1:0]      num_q, num_d;
  logic [NUM_LAYERS-1:0] layer_ena_q, layer_ena_d;
  logic [NUM_LAYERS-1:0] layer_rstn_q, layer_rstn_d;
  logic                  cur_done_c, cur_ovf_c, mux_en_c;

  always_ff @(posedge clk or negedge iRst_n) begin
    if (!iRst_n) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      wdog_q       <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      ovf_q        <= 1'b0;
      timeout_q    <= 1'b0;
      num_q        <= '0;
      layer_ena_q  <= '0;
      layer_rstn_q <= '1;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      wdog_q       <= wdog_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      ovf_q        <= ovf_d;
      timeout_q    <= timeout_d;
      num_q        <= num_d;
      layer_ena_q  <= layer_ena_d;
      layer_rstn_q <= layer_rstn_d;
    end
  end

  // Status of the currently selected engine.
  always_comb begin
    cur_done_c = 1'b0;
    cur_ovf_c  = 1'b0;
    for (int i = 0; i < NUM_LAYERS; i++) begin
      if (idx_q == IDX_BITS'(i)) begin
        cur_done_c = layer_done[i];
        cur_ovf_c  = layer_ovf[i];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    wdog_d    = wdog_q;
    busy_d    = busy_q;
    done_d    = done_q;
    ovf_d     = ovf_q;
    timeout_d = timeout_q;
    num_d     = num_q;
    if (ena) begin
      unique case (state_q)
        IDLE, DONE, ERR: begin
          if (start) begin
            done_d    = 1'b0;
            ovf_d     = 1'b0;
            timeout_d = 1'b0;
            idx_d     = '0;
            busy_d    = 1'b1;
            state_d   = RST;
          end
        end
        RST: begin
          wdog_d  = '0;
          state_d = RUN;
        end
        RUN: begin
          if (cur_done_c) begin
            ovf_d = ovf_q | cur_ovf_c;
            if (idx_q == IDX_BITS'(NUM_LAYERS - 1)) begin
              num_d   = class_index;
              done_d  = 1'b1;
              busy_d  = 1'b0;
              state_d = DONE;
            end else begin
              idx_d   = idx_q + IDX_BITS'(1);
              state_d = RST;
            end
          end else if ((TIMEOUT_CYC != 0) && (wdog_q == WDOG_W'(TIMEOUT_CYC - 1))) begin
            timeout_d = 1'b1;
            done_d    = 1'b1;
            busy_d    = 1'b0;
            state_d   = ERR;
          end else begin
            wdog_d = wdog_q + WDOG_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Engine enable/reset strobes decoded from the next state so they register glitch-free.
  always_comb begin
    layer_ena_d  = '0;
    layer_rstn_d = '1;
    for (int i = 0; i < NUM_LAYERS; i++) begin
      if (idx_d == IDX_BITS'(i)) begin
        layer_ena_d[i]  = (state_d == RST) || (state_d == RUN);
        layer_rstn_d[i] = (state_d != RST);
      end
    end
  end

  assign mux_en_c = (state_q == RST) || (state_q == RUN);

  tpu_operand_mux #(.WIDTH(ADDR_W), .N(NUM_LAYERS), .SEL_W(IDX_BITS)) u_addr_mux (
    .in_flat(layer_addr), .sel(idx_q), .en(mux_en_c), .out_c(rom_addr)
  );

  tpu_operand_mux #(.WIDTH(OPR_W), .N(NUM_LAYERS), .SEL_W(IDX_BITS)) u_opr1_mux (
    .in_flat(layer_opr1), .sel(idx_q), .en(mux_en_c), .out_c(mac_opr1)
  );

  tpu_operand_mux #(.WIDTH(OPR_W), .N(NUM_LAYERS), .SEL_W(IDX_BITS)) u_opr2_mux (
    .in_flat(layer_opr2), .sel(idx_q), .en(mux_en_c), .out_c(mac_opr2)
  );

  assign layer_ena  = layer_ena_q;
  assign layer_rstn = layer_rstn_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign overflow   = ovf_q;
  assign timeout    = timeout_q;
  assign num_out    = num_q;

endmodule

// File: tb/tb_tpu_layer_sequencer.sv
// Self-checking bench for tpu_layer_sequencer with two stub engines and a result scoreboard.
module tb_tpu_layer_sequencer;

  localparam int unsigned NL = 2;
  localparam int unsigned BW = 16;
  localparam int unsigned LN = 4;
  localparam int unsigned AW = 11;
  localparam int unsigned IW = 4;
  localparam int unsigned TO = 16;
  localparam int unsigned OW = LN * BW;

  logic clk = 1'b0;
  logic iRst_n = 1'b0;
  logic ena = 1'b0;
  logic start = 1'b0;
  logic [NL-1:0]    layer_done, layer_ovf;
  logic [NL*AW-1:0] layer_addr;
  logic [NL*OW-1:0] layer_opr1, layer_opr2;
  logic [IW-1:0]    class_index = '0;
  logic [NL-1:0]    layer_ena, layer_rstn;
  logic [AW-1:0]    rom_addr;
  logic [OW-1:0]    mac_opr1, mac_opr2;
  logic             busy, done, overflow, timeout;
  logic [IW-1:0]    num_out;

  logic [AW-1:0] apat [NL];
  logic [OW-1:0] p1pat [NL];
  logic [OW-1:0] p2pat [NL];
  logic          ovf_pat [NL] = '{default: 1'b0};
  int            dly [NL] = '{default: 0};
  int            cnt [NL] = '{default: 0};

  int n_cmp = 0;
  int n_err = 0;
  logic [IW-1:0] num_model = '0;

  typedef struct {
    int            lat;
    logic          ovf;
    logic          to;
    logic [IW-1:0] num;
  } exp_t;
  exp_t sb[$];

  tpu_layer_sequencer #(
    .NUM_LAYERS(NL), .BIT(BW), .LANES(LN), .ADDR_W(AW), .IDX_W(IW), .TIMEOUT_CYC(TO)
  ) dut (
    .clk(clk), .iRst_n(iRst_n), .ena(ena), .start(start),
    .layer_done(layer_done), .layer_ovf(layer_ovf), .layer_addr(layer_addr),
    .layer_opr1(layer_opr1), .layer_opr2(layer_opr2), .class_index(class_index),
    .layer_ena(layer_ena), .layer_rstn(layer_rstn), .rom_addr(rom_addr),
    .mac_opr1(mac_opr1), .mac_opr2(mac_opr2), .busy(busy), .done(done),
    .overflow(overflow), .timeout(timeout), .num_out(num_out)
  );

  always #5 clk = ~clk;

  // Stub engines: raise done in their dly-th RUN cycle; dly==0 means never.
  always_comb begin
    for (int k = 0; k < NL; k++) begin
      layer_addr[k*AW +: AW] = apat[k];
      layer_opr1[k*OW +: OW] = p1pat[k];
      layer_opr2[k*OW +: OW] = p2pat[k];
      layer_ovf[k]           = ovf_pat[k];
      layer_done[k]          = layer_ena[k] && layer_rstn[k] && (dly[k] != 0) && (cnt[k] >= dly[k] - 1);
    end
  end

  always @(posedge clk) begin
    for (int k = 0; k < NL; k++) begin
      if (!layer_rstn[k]) cnt[k] <= 0;
      else if (layer_ena[k] && ena) cnt[k] <= cnt[k] + 1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic new_patterns();
    apat[0]  = AW'($urandom_range(1, 1022));
    apat[1]  = ~apat[0];
    p1pat[0] = {$urandom, $urandom} | 64'h1;
    p1pat[1] = {$urandom, $urandom} | 64'h2;
    p2pat[0] = {$urandom, $urandom} | 64'h4;
    p2pat[1] = {$urandom, $urandom} | 64'h8;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_busy"}, 64'(busy), 64'(0));
    chk({tag, "_done"}, 64'(done), 64'(0));
    chk({tag, "_ovf"}, 64'(overflow), 64'(0));
    chk({tag, "_timeout"}, 64'(timeout), 64'(0));
    chk({tag, "_num_out"}, 64'(num_out), 64'(0));
    chk({tag, "_layer_ena"}, 64'(layer_ena), 64'(0));
    chk({tag, "_layer_rstn"}, 64'(layer_rstn), 64'(2'b11));
    chk({tag, "_rom_addr"}, 64'(rom_addr), 64'(0));
    chk({tag, "_opr1"}, 64'(mac_opr1), 64'(0));
    chk({tag, "_opr2"}, 64'(mac_opr2), 64'(0));
  endtask

  // Expected outputs after eff enabled clock edges since the start sample.
  task automatic chk_cycle(input int eff, input int d0, input int l_end, input bit ovf0,
                           input bit ovf1, input bit exp_to, input logic [IW-1:0] cls);
    int act;
    bit in_rst;
    logic [NL-1:0] e_ena, e_rstn;
    logic [AW-1:0] e_addr;
    logic [OW-1:0] e_p1, e_p2;
    act = -1;
    in_rst = 1'b0;
    if (eff <= d0) begin
      act = 0;
      in_rst = (eff == 0);
    end else if (eff < l_end) begin
      act = 1;
      in_rst = (eff == d0 + 1);
    end
    e_ena = '0; e_rstn = '1; e_addr = '0; e_p1 = '0; e_p2 = '0;
    if (act >= 0) begin
      e_ena[act] = 1'b1;
      e_rstn[act] = !in_rst;
      e_addr = apat[act];
      e_p1 = p1pat[act];
      e_p2 = p2pat[act];
    end
    chk("layer_ena", 64'(layer_ena), 64'(e_ena));
    chk("layer_rstn", 64'(layer_rstn), 64'(e_rstn));
    chk("rom_addr", 64'(rom_addr), 64'(e_addr));
    chk("mac_opr1", mac_opr1, e_p1);
    chk("mac_opr2", mac_opr2, e_p2);
    chk("busy", 64'(busy), 64'(eff < l_end));
    chk("overflow", 64'(overflow), 64'(((eff > d0) && ovf0) || ((eff >= l_end) && !exp_to && ovf1)));
    chk("timeout", 64'(timeout), 64'((eff >= l_end) && exp_to));
    chk("num_out", 64'(num_out), 64'(((eff >= l_end) && !exp_to) ? cls : num_model));
  endtask

  task automatic run_inf(input int d0, input int d1, input bit ovf0, input bit ovf1,
                         input logic [IW-1:0] cls, input int stall_at, input int stall_len,
                         input int start_at);
    exp_t e;
    int d1e, l_end, total, eff;
    bit seen, en_now;
    d1e = (d1 == 0) ? int'(TO) : d1;
    l_end = d0 + d1e + 2;
    total = 0; eff = 0; seen = 1'b0;
    new_patterns();
    dly[0] = d0; dly[1] = d1;
    ovf_pat[0] = ovf0; ovf_pat[1] = ovf1;
    class_index = cls;
    e.lat = l_end + stall_len;
    e.to  = (d1 == 0);
    e.ovf = ovf0 || (!e.to && ovf1);
    e.num = e.to ? num_model : cls;
    sb.push_back(e);
    @(negedge clk); start = 1'b1; ena = 1'b1;
    @(negedge clk); start = 1'b0;
    while (!seen && total <= e.lat + 4) begin
      chk_cycle(eff, d0, l_end, ovf0, ovf1, e.to, cls);
      if (done) begin
        seen = 1'b1;
        e = sb.pop_front();
        chk("latency", 64'(total), 64'(e.lat));
        chk("end_num_out", 64'(num_out), 64'(e.num));
        chk("end_overflow", 64'(overflow), 64'(e.ovf));
        chk("end_timeout", 64'(timeout), 64'(e.to));
        chk("end_busy", 64'(busy), 64'(0));
        num_model = e.num;
      end else begin
        en_now = !((total >= stall_at) && (total < stall_at + stall_len));
        ena = en_now;
        start = (total == start_at);
        @(negedge clk);
        start = 1'b0;
        total++;
        if (en_now) eff++;
      end
    end
    if (!seen) begin
      chk("done_seen", 64'(0), 64'(1));
      e = sb.pop_front();
    end
    ena = 1'b1;
  endtask

  initial begin
    new_patterns();
    #12;
    chk_reset_vals("por");
    @(negedge clk); iRst_n = 1'b1; ena = 1'b1;
    repeat (2) @(negedge clk);
    chk_reset_vals("idle");

    // Engine 1 hangs: watchdog abort with num_out left at its reset value.
    run_inf(4, 0, 1'b0, 1'b0, 4'd9, -1, 0, -1);
    chk("err_num_out", 64'(num_out), 64'(0));

    // Nominal two-layer run: 10 cycles, class 7.
    run_inf(5, 3, 1'b0, 1'b0, 4'd7, -1, 0, -1);

    // Overflow from engine 0 is sticky after completion.
    run_inf(2, 4, 1'b1, 1'b0, 4'd3, -1, 0, -1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("ovf_sticky", 64'(overflow), 64'(1));
      chk("done_hold", 64'(done), 64'(1));
    end

    // Enable stall mid-RUN near the watchdog limit, plus a start pulse while busy.
    run_inf(14, 3, 1'b0, 1'b0, 4'd5, 5, 4, 3);

    // Asynchronous reset mid-RUN between clock edges.
    new_patterns();
    dly[0] = 2; dly[1] = 10; ovf_pat[0] = 1'b1; ovf_pat[1] = 1'b0; class_index = 4'd6;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (5) @(negedge clk);
    chk("pre_rst_ovf", 64'(overflow), 64'(1));
    chk("pre_rst_busy", 64'(busy), 64'(1));
    chk("pre_rst_num", 64'(num_out), 64'(5));
    #2 iRst_n = 1'b0;
    #1 chk_reset_vals("async_rst");
    num_model = '0;
    @(negedge clk); iRst_n = 1'b1;
    run_inf(3, 2, 1'b0, 1'b1, 4'd11, -1, 0, -1);

    chk("sb_empty", 64'(sb.size()), 64'(0));
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
